prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_pkg.sv | 24 ++
 rtl/prog_loader_if.sv | 32 +++
 rtl/lat_counter.sv | 37 +++
 rtl/prog_loader.sv | 150 +++++++++++++++
 tb/tb_prog_loader.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/prog_pkg.sv
// Shared types and default parameter values for the program loader.
// Imported by the interface, the loader top and its down-counter.
package prog_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StWrite,
        StHold,
        StRun
    } state_e;

    localparam int unsigned DefDataW     = 32;
    localparam int unsigned DefAddrW     = 9;
    localparam int unsigned DefLoadWords = 512;
    localparam int unsigned DefRomLat    = 1;
    localparam int unsigned DefHoldCyc   = 4;
    localparam bit          DefAutoStart = 1'b1;

    // Wide enough for HOLD_CYC-1 (max 14) and ROM_LAT-2 (max 2).
    localparam int unsigned CntW = 4;

endpackage

// File: rtl/prog_loader_if.sv
// ROM read port and instruction-RAM write port seen by the program loader.
// The loader takes the master side; the memories take the slave side.
interface prog_loader_if
    import prog_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
) ();

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    modport master (
        output rom_addr,
        input  rom_data,
        output ram_we,
        output ram_addr,
        output ram_wdata
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata
    );

endinterface

// File: rtl/lat_counter.sv
// Loadable down-counter shared by the ROM wait and core-reset hold phases.
// zero_o reflects the registered count, so a load of N gives N+1 cycles to zero.
module lat_counter
    import prog_pkg::*;
#(
    parameter int unsigned W = CntW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/prog_loader.sv
// Copies LOAD_WORDS words from a fixed-latency ROM into instruction RAM while
// holding the core in reset, then releases it; a start pulse in RUN reloads.
module prog_loader
    import prog_pkg::*;
#(
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned ADDR_W     = DefAddrW,
    parameter int unsigned LOAD_WORDS = DefLoadWords,
    parameter int unsigned ROM_LAT    = DefRomLat,
    parameter int unsigned HOLD_CYC   = DefHoldCyc,
    parameter bit          AUTO_START = DefAutoStart
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    prog_loader_if.master    bus,
    output logic             core_rst,
    output logic             busy,
    output logic             done
);

    localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(LOAD_WORDS - 1);
    localparam logic [CntW-1:0]   WaitLoad = CntW'((ROM_LAT >= 2) ? (ROM_LAT - 2) : 0);
    localparam logic [CntW-1:0]   HoldLoad = CntW'(HOLD_CYC - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              core_rst_q, core_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              cnt_load;
    logic [CntW-1:0]   cnt_load_val;
    logic              cnt_dec;
    logic              cnt_zero;

    lat_counter #(
        .W (CntW)
    ) u_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_load     = 1'b0;
        cnt_load_val = WaitLoad;
        cnt_dec      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (AUTO_START || start) begin
                    state_d = StFetch;
                    idx_d   = '0;
                end
            end
            StFetch: begin
                if (ROM_LAT < 2) begin
                    state_d = StWrite;
                end else begin
                    state_d      = StWait;
                    cnt_load     = 1'b1;
                    cnt_load_val = WaitLoad;
                end
            end
            StWait: begin
                if (cnt_zero) begin
                    state_d = StWrite;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StWrite: begin
                if (idx_q == LastIdx) begin
                    state_d      = StHold;
                    cnt_load     = 1'b1;
                    cnt_load_val = HoldLoad;
                end else begin
                    state_d = StFetch;
                    idx_d   = idx_q + ADDR_W'(1);
                end
            end
            StHold: begin
                if (cnt_zero) begin
                    state_d = StRun;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StRun: begin
                if (start) begin
                    state_d = StFetch;
                    idx_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they line up with it once registered.
        rom_addr_d  = (state_d == StFetch) ? idx_d : rom_addr_q;
        ram_we_d    = (state_d == StWrite);
        ram_addr_d  = ram_we_d ? idx_d : ram_addr_q;
        ram_wdata_d = ram_we_d ? bus.rom_data : ram_wdata_q;
        core_rst_d  = (state_d != StRun);
        busy_d      = (state_d inside {StFetch, StWait, StWrite, StHold});
        done_d      = (state_d == StRun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            rom_addr_q  <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            core_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rom_addr_q  <= rom_addr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign core_rst      = core_rst_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: four differently configured loaders share one clock,
// each fed by a ROM model whose data is BASE + address, delayed by ROM_LAT.
module tb_prog_loader;

    localparam int N = 4;
    // Inst 0: basic load, ignored start, restart. 1: ROM_LAT=3. 2: single word, no autostart.
    // Inst 3: reset abort during a WAIT.
    localparam int unsigned LW   [N] = '{4, 2, 1, 4};
    localparam int unsigned LAT  [N] = '{1, 3, 2, 2};
    localparam int unsigned HOLD [N] = '{4, 2, 1, 3};
    localparam int unsigned AUTO [N] = '{1, 1, 0, 1};
    localparam logic [31:0] BASE [N] = '{32'hA0, 32'hB0, 32'hC0, 32'hD0};

    typedef struct {
        int          t;
        int          a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [N];
    logic        start      [N];
    logic        core_rst_w [N];
    logic        busy_w     [N];
    logic        done_w     [N];
    logic        we_w       [N];
    logic [8:0]  rom_addr_w [N];
    logic [8:0]  ram_addr_w [N];
    logic [31:0] wdata_w    [N];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        prog_loader_if #(.DATA_W(32), .ADDR_W(9)) bus ();
        logic [8:0] pipe [3];
        logic [8:0] eff_addr;

        always @(posedge clk) begin
            pipe[0] <= bus.rom_addr;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        if (LAT[g] == 1) begin : g_comb
            assign eff_addr = bus.rom_addr;
        end else begin : g_pipe
            assign eff_addr = pipe[LAT[g]-2];
        end
        assign bus.rom_data = BASE[g] + {23'd0, eff_addr};

        prog_loader #(
            .DATA_W     (32),
            .ADDR_W     (9),
            .LOAD_WORDS (LW[g]),
            .ROM_LAT    (LAT[g]),
            .HOLD_CYC   (HOLD[g]),
            .AUTO_START (AUTO[g] != 0)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .start    (start[g]),
            .bus      (bus),
            .core_rst (core_rst_w[g]),
            .busy     (busy_w[g]),
            .done     (done_w[g])
        );

        assign we_w[g]       = bus.ram_we;
        assign rom_addr_w[g] = bus.rom_addr;
        assign ram_addr_w[g] = bus.ram_addr;
        assign wdata_w[g]    = bus.ram_wdata;
    end

    wr_t  wq    [N][$];
    int   drise [N] = '{default: 0};
    int   dcyc  [N] = '{default: 0};
    logic done_p[N];

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (we_w[i] === 1'b1) wq[i].push_back('{t: cyc, a: int'(ram_addr_w[i]), d: wdata_w[i]});
            if (done_w[i] === 1'b1 && done_p[i] !== 1'b1) begin
                drise[i]++;
                dcyc[i] = cyc;
            end
            done_p[i] = done_w[i];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int i, input int bound, input string tag);
        int k;
        k = 0;
        while (done_w[i] !== 1'b1 && k < bound) begin
            tick();
            k++;
        end
        check(tag, 64'(done_w[i]), 64'd1);
    endtask

    // {rom_addr, ram_addr, ram_wdata, ram_we, core_rst, busy, done}
    function automatic logic [63:0] outs(input int i);
        return 64'({rom_addr_w[i], ram_addr_w[i], wdata_w[i], we_w[i], core_rst_w[i],
                    busy_w[i], done_w[i]});
    endfunction

    localparam logic [63:0] RstVec = 64'({9'd0, 9'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0});

    initial begin
        int b;
        int k;
        logic bad;
        for (int i = 0; i < N; i++) begin
            rst[i]   = 1'b1;
            start[i] = 1'b0;
        end
        repeat (3) tick();
        for (int i = 0; i < N; i++) check($sformatf("reset_state%0d", i), outs(i), RstVec);

        for (int i = 0; i < N; i++) rst[i] = 1'b0;
        tick();
        check("a_first_fetch", 64'({busy_w[0], rom_addr_w[0]}), 64'({1'b1, 9'd0}));
        check("c_no_autostart", 64'(busy_w[2]), 64'd0);

        // Start while busy must be ignored.
        tick();
        tick();
        start[0] = 1'b1;
        start[1] = 1'b1;
        tick();
        start[0] = 1'b0;
        start[1] = 1'b0;

        bad = 1'b0;
        for (int j = 0; j < 100; j++) begin
            if (outs(2) !== RstVec) bad = 1'b1;
            tick();
        end
        check("c_idle_100", 64'(bad), 64'd0);

        check("a_done_once", 64'(drise[0]), 64'd1);
        check("a_run_outs", 64'({core_rst_w[0], busy_w[0], done_w[0]}), 64'b001);
        check("a_nwrites", 64'(wq[0].size()), 64'd4);
        for (int j = 0; j < 4 && j < wq[0].size(); j++) begin
            check($sformatf("a_addr%0d", j), 64'(wq[0][j].a), 64'(j));
            check($sformatf("a_data%0d", j), 64'(wq[0][j].d), 64'(32'hA0 + j));
            if (j > 0) check($sformatf("a_space%0d", j), 64'(wq[0][j].t - wq[0][j-1].t), 64'd2);
        end
        if (wq[0].size() == 4) check("a_release_gap", 64'(dcyc[0] - wq[0][3].t), 64'd5);

        check("b_done_once", 64'(drise[1]), 64'd1);
        check("b_nwrites", 64'(wq[1].size()), 64'd2);
        for (int j = 0; j < 2 && j < wq[1].size(); j++) begin
            check($sformatf("b_addr%0d", j), 64'(wq[1][j].a), 64'(j));
            check($sformatf("b_data%0d", j), 64'(wq[1][j].d), 64'(32'hB0 + j));
        end
        if (wq[1].size() == 2) begin
            check("b_space", 64'(wq[1][1].t - wq[1][0].t), 64'd4);
            check("b_release_gap", 64'(dcyc[1] - wq[1][1].t), 64'd3);
        end

        // Single-word load on the manual-start instance.
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        check("c_start_busy", 64'({busy_w[2], core_rst_w[2]}), 64'b11);
        wait_done(2, 30, "c_done");
        check("c_nwrites", 64'(wq[2].size()), 64'd1);
        if (wq[2].size() == 1) begin
            check("c_write0", 64'({wq[2][0].a, wq[2][0].d}), 64'({32'd0, 32'hC0}));
            check("c_release_gap", 64'(dcyc[2] - wq[2][0].t), 64'd2);
        end

        // Restart from RUN.
        b = wq[0].size();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("a_restart_outs", 64'({core_rst_w[0], busy_w[0], done_w[0], rom_addr_w[0]}),
              64'({1'b1, 1'b1, 1'b0, 9'd0}));
        wait_done(0, 40, "a_reload_done");
        check("a_reload_nwrites", 64'(wq[0].size() - b), 64'd4);
        if (wq[0].size() - b == 4) begin
            check("a_reload_first", 64'(wq[0][b].a), 64'd0);
            check("a_reload_last", 64'({wq[0][b+3].a, wq[0][b+3].d}), 64'({32'd3, 32'hA3}));
        end
        check("a_done_twice", 64'(drise[0]), 64'd2);

        // Abort with rst during the third word's WAIT.
        start[3] = 1'b1;
        tick();
        start[3] = 1'b0;
        k = 0;
        while (!(rom_addr_w[3] == 9'd2 && busy_w[3] === 1'b1) && k < 40) begin
            tick();
            k++;
        end
        check("d_reach_word2", 64'(rom_addr_w[3]), 64'd2);
        tick();
        rst[3] = 1'b1;
        b = wq[3].size();
        tick();
        rst[3] = 1'b0;
        check("d_abort_outs", outs(3), RstVec);
        wait_done(3, 60, "d_reload_done");
        check("d_nwrites", 64'(wq[3].size() - b), 64'd4);
        for (int j = 0; j < 4 && b + j < wq[3].size(); j++) begin
            check($sformatf("d_addr%0d", j), 64'(wq[3][b+j].a), 64'(j));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
